// File: rtl/legv8_pkg.sv
// +----------------------------------------------------------------------------+
// | legv8_pkg: shared opcodes, ALU-op classes and pipeline control bundles.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package legv8_pkg;

  localparam int OPC_W   = 11;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 2;

  localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
  localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
  localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
  localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
  localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
  localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]       OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]       OPC_B    = 6'b000101;

  localparam logic [ALUOP_W-1:0] ALUOP_LDST  = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [REG_W-1:0] XZR = 5'd31;

  typedef struct packed {
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic uncond_branch;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t         ex;
    mem_ctrl_t        mem;
    wb_ctrl_t         wb;
    logic [REG_W-1:0] dest;
  } idex_t;

  typedef struct packed {
    mem_ctrl_t        mem;
    wb_ctrl_t         wb;
    logic [REG_W-1:0] dest;
  } exmem_t;

  typedef struct packed {
    wb_ctrl_t         wb;
    logic [REG_W-1:0] dest;
  } memwb_t;

endpackage

`default_nettype wire

// File: rtl/legv8_decoder.sv
// +----------------------------------------------------------------------------+
// | legv8_decoder: combinational LEGv8 opcode to control-bundle decode.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module legv8_decoder
  import legv8_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output ex_ctrl_t         ex_o,
  output mem_ctrl_t        mem_o,
  output wb_ctrl_t         wb_o,
  output logic             reg2loc_o,
  output logic             reads_rm_o,
  output logic             legal_o
);

  always_comb begin
    ex_o       = '0;
    mem_o      = '0;
    wb_o       = '0;
    reg2loc_o  = 1'b0;
    reads_rm_o = 1'b0;
    legal_o    = 1'b1;
    if (opcode_i == OPC_ADD || opcode_i == OPC_SUB ||
        opcode_i == OPC_AND || opcode_i == OPC_ORR) begin
      wb_o.reg_write = 1'b1;
      ex_o.alu_op    = ALUOP_RTYPE;
      reads_rm_o     = 1'b1;
    end else if (opcode_i == OPC_LDUR) begin
      ex_o.alu_src    = 1'b1;
      ex_o.alu_op     = ALUOP_LDST;
      mem_o.mem_read  = 1'b1;
      wb_o.mem_to_reg = 1'b1;
      wb_o.reg_write  = 1'b1;
    end else if (opcode_i == OPC_STUR) begin
      reg2loc_o       = 1'b1;
      reads_rm_o      = 1'b1;
      ex_o.alu_src    = 1'b1;
      ex_o.alu_op     = ALUOP_LDST;
      mem_o.mem_write = 1'b1;
    end else if (opcode_i[OPC_W-1 -: 8] == OPC_CBZ) begin
      reg2loc_o    = 1'b1;
      reads_rm_o   = 1'b1;
      mem_o.branch = 1'b1;
      ex_o.alu_op  = ALUOP_CBZ;
    end else if (opcode_i[OPC_W-1 -: 6] == OPC_B) begin
      mem_o.uncond_branch = 1'b1;
    end else begin
      legal_o = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipelined_controller.sv
// +----------------------------------------------------------------------------+
// | pipelined_controller: LEGv8 ID decode with ID/EX, EX/MEM, MEM/WB control   |
// | pipeline, load-use stall and branch flush. Revision: 1.0                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipelined_controller
  import legv8_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned ALUOP_WIDTH    = 2,
  parameter bit          HAZARD_EN      = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [INSTR_WIDTH-1:0]    instruction,
  input  logic                      instrValid,
  input  logic                      flush,
  output logic                      stallFetch,
  output logic [REG_ADDR_WIDTH-1:0] readRegister1,
  output logic [REG_ADDR_WIDTH-1:0] readRegister2,
  output logic                      exAluSRC,
  output logic [ALUOP_WIDTH-1:0]    exAluOP,
  output logic [REG_ADDR_WIDTH-1:0] exWriteRegister,
  output logic                      memBranch,
  output logic                      memUnconditionalBranch,
  output logic                      memRead,
  output logic                      memWrite,
  output logic                      wbMemToReg,
  output logic                      wbRegWrite,
  output logic [REG_ADDR_WIDTH-1:0] wbWriteRegister,
  output logic                      illegalOpcode
);

  ex_ctrl_t         dec_ex;
  mem_ctrl_t        dec_mem;
  wb_ctrl_t         dec_wb;
  logic             dec_reg2loc;
  logic             dec_reads_rm;
  logic             dec_legal;
  logic [REG_W-1:0] rr1_w;
  logic [REG_W-1:0] rr2_w;
  logic             hazard;
  logic             unused_fields;

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  logic   illegal_q, illegal_d;

  legv8_decoder u_decoder (
    .opcode_i   (instruction[INSTR_WIDTH-1 -: OPC_W]),
    .ex_o       (dec_ex),
    .mem_o      (dec_mem),
    .wb_o       (dec_wb),
    .reg2loc_o  (dec_reg2loc),
    .reads_rm_o (dec_reads_rm),
    .legal_o    (dec_legal)
  );

  // Shift amount / address offset bits carry no control information.
  assign unused_fields = ^instruction[15:10];

  assign rr1_w = instruction[9:5];
  assign rr2_w = dec_reg2loc ? instruction[4:0] : instruction[20:16];

  generate
    if (HAZARD_EN) begin : g_hazard
      // A load writing XZR never produces a value anyone can depend on.
      assign hazard = instrValid && idex_q.mem.mem_read && (idex_q.dest != XZR) &&
                      ((idex_q.dest == rr1_w) || (dec_reads_rm && (idex_q.dest == rr2_w)));
    end else begin : g_no_hazard
      assign hazard = 1'b0;
    end
  endgenerate

  assign stallFetch = hazard && !flush;

  always_comb begin
    memwb_d   = '{wb: exmem_q.wb, dest: exmem_q.dest};
    exmem_d   = '0;
    idex_d    = '0;
    illegal_d = instrValid && !dec_legal && !flush && !hazard;
    if (!flush) begin
      exmem_d = '{mem: idex_q.mem, wb: idex_q.wb, dest: idex_q.dest};
      if (instrValid && dec_legal && !hazard) begin
        idex_d = '{ex: dec_ex, mem: dec_mem, wb: dec_wb, dest: instruction[4:0]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idex_q    <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      illegal_q <= illegal_d;
    end
  end

  assign readRegister1          = REG_ADDR_WIDTH'(rr1_w);
  assign readRegister2          = REG_ADDR_WIDTH'(rr2_w);
  assign exAluSRC               = idex_q.ex.alu_src;
  assign exAluOP                = ALUOP_WIDTH'(idex_q.ex.alu_op);
  assign exWriteRegister        = REG_ADDR_WIDTH'(idex_q.dest);
  assign memBranch              = exmem_q.mem.branch;
  assign memUnconditionalBranch = exmem_q.mem.uncond_branch;
  assign memRead                = exmem_q.mem.mem_read;
  assign memWrite               = exmem_q.mem.mem_write;
  assign wbMemToReg             = memwb_q.wb.mem_to_reg;
  assign wbRegWrite             = memwb_q.wb.reg_write;
  assign wbWriteRegister        = REG_ADDR_WIDTH'(memwb_q.dest);
  assign illegalOpcode          = illegal_q;

endmodule

`default_nettype wire
